// File: rtl/rr_mux.sv
// rr_mux: N-channel registered multiplexer with round-robin arbitration.
// A one-entry output stage holds the winning word tagged with its source channel.
module rr_mux #(
  parameter int N = 4,
  parameter int W = 8,
  parameter int S = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   in_data_i,
  input  logic [N-1:0]     in_valid_i,
  output logic [N-1:0]     in_ready_o,
  output logic [W-1:0]     out_data_o,
  output logic [S-1:0]     out_sel_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic [S:0] NUM_CH = (S+1)'(N);
  localparam logic [S:0] ONE    = {{S{1'b0}}, 1'b1};

  state_t         state_q;
  logic [W-1:0]   data_q;
  logic [S-1:0]   sel_q;
  logic [S-1:0]   ptr_q;
  logic [S-1:0]   ptr_d;

  logic           load_en_s;
  logic           grant_s;
  logic           hit_s;
  logic [S-1:0]   cand_s;
  logic [S-1:0]   gidx_s;
  logic [N-1:0]   grant_oh_s;
  logic [W-1:0]   win_data_s;

  // Channel indices stay in [0, N-1] even when N is not a power of two.
  function automatic logic [S-1:0] mod_add(input logic [S-1:0] base, input logic [S:0] off);
    logic [S:0] sum;
    logic [S:0] wrapped;
    sum     = {1'b0, base} + off;
    wrapped = (sum >= NUM_CH) ? (sum - NUM_CH) : sum;
    return wrapped[S-1:0];
  endfunction

  assign load_en_s = (state_q == ST_EMPTY) || out_ready_i;

  // Round-robin search starting at ptr_q; first valid channel wins.
  always_comb begin
    grant_s    = 1'b0;
    hit_s      = 1'b0;
    cand_s     = '0;
    gidx_s     = '0;
    grant_oh_s = '0;
    for (int k = 0; k < N; k++) begin
      cand_s             = mod_add(ptr_q, k[S:0]);
      hit_s              = !grant_s && in_valid_i[cand_s];
      gidx_s             = hit_s ? cand_s : gidx_s;
      grant_oh_s[cand_s] = grant_oh_s[cand_s] | hit_s;
      grant_s            = grant_s | hit_s;
    end
  end

  // Winning channel data selected through the one-hot grant.
  always_comb begin
    win_data_s = '0;
    for (int i = 0; i < N; i++) begin
      win_data_s = win_data_s | (in_data_i[i*W +: W] & {W{grant_oh_s[i]}});
    end
  end

  // Handshake back to producers: only the winner, only when the stage can load.
  always_comb begin
    if (load_en_s) begin
      in_ready_o = grant_oh_s;
    end else begin
      in_ready_o = '0;
    end
  end

  assign ptr_d = mod_add(gidx_s, ONE);

  // Output stage FSM: EMPTY/FULL mirrored on out_valid; ptr moves only on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (grant_s) begin
            state_q <= ST_FULL;
            data_q  <= win_data_s;
            sel_q   <= gidx_s;
            ptr_q   <= ptr_d;
          end else begin
            state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // Drain and refill in the same cycle keeps one word per cycle.
          if (out_ready_i && grant_s) begin
            state_q <= ST_FULL;
            data_q  <= win_data_s;
            sel_q   <= gidx_s;
            ptr_q   <= ptr_d;
          end else if (out_ready_i) begin
            state_q <= ST_EMPTY;
          end else begin
            state_q <= ST_FULL;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
        end
      endcase
    end
  end

  assign out_valid_o = (state_q == ST_FULL);
  assign out_data_o  = data_q;
  assign out_sel_o   = sel_q;

endmodule

// File: tb/tb_rr_mux.sv
// tb_rr_mux: scoreboard bench for rr_mux (N=4 main instance, N=3 wrap instance).
// A queue-and-modulo reference model predicts grants; monitors check handshaked words.
module tb_rr_mux;

  localparam int N = 4;
  localparam int W = 8;
  localparam int S = 2;

  typedef struct {
    logic [W-1:0] data;
    int           sel;
  } item_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [S-1:0]   out_sel;
  logic           out_valid;
  logic           out_ready;

  logic           rst3_n;
  logic [3*W-1:0] in_data3;
  logic [2:0]     in_valid3;
  logic [2:0]     in_ready3;
  logic [W-1:0]   out_data3;
  logic [1:0]     out_sel3;
  logic           out_valid3;
  logic           out_ready3;

  int    checks = 0;
  int    errors = 0;
  item_t exp_q[$];
  item_t q3[$];
  int    m_ptr;
  bit    m_full;
  int    last_acc;
  bit    done3 = 1'b0;
  logic [W-1:0] ch_data [N];
  bit           ch_valid[N];

  rr_mux #(.N(N), .W(W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_data_o(out_data), .out_sel_o(out_sel), .out_valid_o(out_valid),
    .out_ready_i(out_ready)
  );

  rr_mux #(.N(3), .W(W)) u_dut3 (
    .clk(clk), .rst_n(rst3_n),
    .in_data_i(in_data3), .in_valid_i(in_valid3), .in_ready_o(in_ready3),
    .out_data_o(out_data3), .out_sel_o(out_sel3), .out_valid_o(out_valid3),
    .out_ready_i(out_ready3)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      in_data[i*W +: W] = ch_data[i];
      in_valid[i]       = ch_valid[i];
    end
  endtask

  task automatic set_all(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      ch_valid[i] = mask[i];
      ch_data[i]  = W'(8'hA0 + i);
    end
  endtask

  // Called at posedge+2 with channel state prepared; returns at the next posedge+2.
  task automatic cycle();
    int g;
    bit load;
    logic [N-1:0] exp_rdy;
    item_t it;
    apply();
    #2;
    check("out_valid", 32'(out_valid), 32'(m_full));
    load = !m_full || out_ready;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && ch_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    exp_rdy = '0;
    if (load && g >= 0) exp_rdy[g] = 1'b1;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    last_acc = -1;
    if (load && g >= 0) begin
      it.data = ch_data[g];
      it.sel  = g;
      exp_q.push_back(it);
      m_full   = 1'b1;
      m_ptr    = (g + 1) % N;
      last_acc = g;
    end else if (load) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #2;
  endtask

  // Reset asserted between edges: outputs must clear without a clock edge.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    exp_q.delete();
    m_full = 1'b0;
    m_ptr  = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Main-instance monitor: every presented word must match the scoreboard head.
  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_word: unexpected word data=%0h sel=%0d at %0t", out_data, out_sel, $time);
      end else begin
        if (out_data !== exp_q[0].data || int'(out_sel) != exp_q[0].sel) begin
          errors++;
          $display("FAIL out_word: got data=%0h sel=%0d expected data=%0h sel=%0d at %0t",
                   out_data, out_sel, exp_q[0].data, exp_q[0].sel, $time);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // N=3 instance monitor.
  initial forever begin
    @(negedge clk);
    if (rst3_n && out_valid3) begin
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL n3_word: unexpected word data=%0h sel=%0d", out_data3, out_sel3);
      end else begin
        if (out_data3 !== q3[0].data || int'(out_sel3) != q3[0].sel) begin
          errors++;
          $display("FAIL n3_word: got data=%0h sel=%0d expected data=%0h sel=%0d",
                   out_data3, out_sel3, q3[0].data, q3[0].sel);
        end
        if (out_ready3) void'(q3.pop_front());
      end
    end
  end

  // N=3 stimulus: all channels held valid, order must be 0,1,2,0,1,2,...
  initial begin
    int p3;
    int g;
    item_t it;
    logic [2:0] exp3;
    rst3_n     = 1'b1;
    in_valid3  = 3'b000;
    out_ready3 = 1'b1;
    in_data3   = {8'hA2, 8'hA1, 8'hA0};
    #3;
    rst3_n = 1'b0;
    @(posedge clk);
    #2;
    rst3_n    = 1'b1;
    p3        = 0;
    in_valid3 = 3'b111;
    repeat (9) begin
      #2;
      g = -1;
      for (int k = 0; k < 3; k++) begin
        if (g < 0 && in_valid3[(p3 + k) % 3]) g = (p3 + k) % 3;
      end
      exp3    = '0;
      exp3[g] = 1'b1;
      check("n3_in_ready", 32'(in_ready3), 32'(exp3));
      it.data = W'(8'hA0 + g);
      it.sel  = g;
      q3.push_back(it);
      p3 = (g + 1) % 3;
      @(posedge clk);
      #2;
    end
    in_valid3 = 3'b000;
    @(posedge clk);
    @(posedge clk);
    done3 = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b1;
    out_ready = 1'b1;
    last_acc  = -1;
    set_all(4'b0000);
    apply();
    #3;
    rst_n = 1'b0;
    #1;
    check("init_out_valid", 32'(out_valid), 32'd0);
    check("init_out_data", 32'(out_data), 32'd0);
    check("init_out_sel", 32'(out_sel), 32'd0);
    m_full = 1'b0;
    m_ptr  = 0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cycle();

    // Single request then drop.
    set_all(4'b0100);
    cycle();
    set_all(4'b0000);
    cycle();
    cycle();

    // Full rotation from a fresh pointer.
    pulse_reset();
    set_all(4'b1111);
    repeat (6) cycle();

    // Backpressure with channel 1 held in the output register (reset drops the FULL word).
    pulse_reset();
    set_all(4'b0010);
    cycle();
    set_all(4'b1111);
    out_ready = 1'b0;
    repeat (3) cycle();
    out_ready = 1'b1;
    cycle();
    cycle();

    // Skip and wrap between channels 3 and 0.
    pulse_reset();
    set_all(4'b0001);
    cycle();
    set_all(4'b1001);
    repeat (3) cycle();

    // Randomised traffic with random backpressure and a mid-run reset.
    for (int c = 0; c < 600; c++) begin
      if (c == 300) pulse_reset();
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (ch_valid[i] && last_acc == i) begin
          ch_valid[i] = ($urandom_range(0, 1) == 1);
          ch_data[i]  = W'($urandom);
        end else if (!ch_valid[i]) begin
          ch_valid[i] = ($urandom_range(0, 2) == 0);
          ch_data[i]  = W'($urandom);
        end
      end
      cycle();
    end

    // Drain.
    out_ready = 1'b1;
    set_all(4'b0000);
    repeat (3) cycle();
    check("main_queue_empty", 32'(exp_q.size()), 32'd0);

    for (int i = 0; i < 200 && !done3; i++) @(posedge clk);
    check("n3_done", 32'(done3), 32'd1);
    check("n3_queue_empty", 32'(q3.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
